// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply and divide unit feeding the HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, with the sign fixed up at the end.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [WIDTH-1:0]   ONE  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE2 = (2 * WIDTH)'(1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   count;
    logic               isDiv;
    logic               negQ;
    logic               negR;
    logic               dbzFlag;
    logic [WIDTH-1:0]   opA;
    logic [WIDTH-1:0]   opB;
    logic [WIDTH-1:0]   accHi;
    logic [WIDTH-1:0]   accLo;

    logic               opSigned;
    logic               aNeg;
    logic               bNeg;
    logic [WIDTH-1:0]   aMag;
    logic [WIDTH-1:0]   bMag;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic [WIDTH:0]     divDiff;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] productFix;
    logic [WIDTH-1:0]   quotFix;
    logic [WIDTH-1:0]   remFix;

    // Operands are reduced to magnitudes at accept time so the datapath is purely unsigned.
    always_comb begin
        opSigned   = ~op[0];
        aNeg       = opSigned & a[WIDTH-1];
        bNeg       = opSigned & b[WIDTH-1];
        aMag       = aNeg ? (~a + ONE) : a;
        bMag       = bNeg ? (~b + ONE) : b;
        mulSum     = {1'b0, accHi} + (accLo[0] ? {1'b0, opA} : '0);
        divShift   = {accHi, accLo[WIDTH-1]};
        divDiff    = divShift - {1'b0, opB};
        product    = {accHi, accLo};
        productFix = negQ ? (~product + ONE2) : product;
        quotFix    = negQ ? (~accLo + ONE) : accLo;
        remFix     = negR ? (~accHi + ONE) : accHi;
    end

    // For multiply accLo starts as the multiplier and fills with product bits;
    // for divide it starts as the dividend and fills with quotient bits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            isDiv   <= 1'b0;
            negQ    <= 1'b0;
            negR    <= 1'b0;
            dbzFlag <= 1'b0;
            opA     <= '0;
            opB     <= '0;
            accHi   <= '0;
            accLo   <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        isDiv <= op[1];
                        negQ  <= aNeg ^ bNeg;
                        negR  <= aNeg;
                        opA   <= aMag;
                        opB   <= bMag;
                        accHi <= '0;
                        accLo <= op[1] ? aMag : bMag;
                        count <= CNT_W'(WIDTH);
                        if (op[1] && (b == '0)) begin
                            hi      <= a;
                            lo      <= '1;
                            dbzFlag <= 1'b1;
                            state   <= DONE;
                        end else begin
                            dbzFlag <= 1'b0;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (isDiv) begin
                        accHi <= divDiff[WIDTH] ? divShift[WIDTH-1:0] : divDiff[WIDTH-1:0];
                        accLo <= {accLo[WIDTH-2:0], ~divDiff[WIDTH]};
                    end else begin
                        accHi <= mulSum[WIDTH:1];
                        accLo <= {mulSum[0], accLo[WIDTH-1:1]};
                    end
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (isDiv) begin
                        hi <= remFix;
                        lo <= quotFix;
                    end else begin
                        {hi, lo} <= productFix;
                    end
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign div_by_zero = (state == DONE) & dbzFlag;

endmodule
